// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter in front of the single register-file write port.
// Stages one accepted ALU or load write per cycle and counts committed non-x0 writes.
module regfile_wb_arbiter #(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 5,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               alu_valid,
    input  logic [ADDR_W-1:0]  alu_rd,
    input  logic [DATA_W-1:0]  alu_data,
    output logic               alu_ready,
    input  logic               mem_valid,
    input  logic [ADDR_W-1:0]  mem_rd,
    input  logic [DATA_W-1:0]  mem_data,
    output logic               mem_ready,
    input  logic               hold,
    output logic               RegWrite,
    output logic [ADDR_W-1:0]  RD,
    output logic [DATA_W-1:0]  WriteData,
    output logic [COUNT_W-1:0] wr_count
);

    localparam logic GRANT_ALU = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic               last_grant_q, last_grant_d;
    logic               reg_write_q, reg_write_d;
    logic [ADDR_W-1:0]  rd_q, rd_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               alu_go, mem_go, accept, commit;
    logic [ADDR_W-1:0]  sel_rd;
    logic [DATA_W-1:0]  sel_data;

    // Grant: a lone requester always wins; on a tie the one not granted last time wins.
    always_comb begin
        alu_go = 1'b0;
        mem_go = 1'b0;
        if (reset && !hold) begin
            if (alu_valid && (!mem_valid || last_grant_q == GRANT_MEM)) begin
                alu_go = 1'b1;
            end else if (mem_valid) begin
                mem_go = 1'b1;
            end
        end
    end

    assign alu_ready = alu_go;
    assign mem_ready = mem_go;
    assign accept    = alu_go | mem_go;
    assign sel_rd    = alu_go ? alu_rd : mem_rd;
    assign sel_data  = alu_go ? alu_data : mem_data;
    // Writes to x0 still complete the handshake but never reach the register file.
    assign commit    = accept && (sel_rd != '0);

    always_comb begin
        last_grant_d = last_grant_q;
        reg_write_d  = commit;
        rd_d         = rd_q;
        wdata_d      = wdata_q;
        count_d      = count_q;
        if (accept) begin
            last_grant_d = alu_go ? GRANT_ALU : GRANT_MEM;
            rd_d         = sel_rd;
            wdata_d      = sel_data;
        end
        if (commit) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GRANT_MEM;
            reg_write_q  <= 1'b0;
            rd_q         <= '0;
            wdata_q      <= '0;
            count_q      <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            reg_write_q  <= reg_write_d;
            rd_q         <= rd_d;
            wdata_q      <= wdata_d;
            count_q      <= count_d;
        end
    end

    assign RegWrite  = reg_write_q;
    assign RD        = rd_q;
    assign WriteData = wdata_q;
    assign wr_count  = count_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset/wrap sequences, random vs model.
module tb_regfile_wb_arbiter;

    localparam int DATA_W  = 64;
    localparam int ADDR_W  = 5;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               alu_valid, mem_valid, hold;
    logic [ADDR_W-1:0]  alu_rd, mem_rd;
    logic [DATA_W-1:0]  alu_data, mem_data;
    logic               alu_ready, mem_ready;
    logic               RegWrite;
    logic [ADDR_W-1:0]  RD;
    logic [DATA_W-1:0]  WriteData;
    logic [COUNT_W-1:0] wr_count;

    int n_cmp  = 0;
    int n_fail = 0;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
        .hold(hold), .RegWrite(RegWrite), .RD(RD), .WriteData(WriteData), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        hold;
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        mv;
        logic [4:0]  mrd;
        logic [63:0] md;
        logic        ear;
        logic        emr;
        logic        ewe;
        logic [4:0]  erd;
        logic [63:0] edata;
        logic        chk_rd;
        int          ecnt;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        hold = 1'b0;
    endtask

    // Reset with requests pending so ready gating is observable, then release mid-cycle.
    task automatic do_reset();
        idle_inputs();
        alu_valid = 1'b1; mem_valid = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_rd", 64'(RD), 64'd0);
        chk("rst_wdata", WriteData, 64'd0);
        chk("rst_count", 64'(wr_count), 64'd0);
        chk("rst_ready", {62'd0, alu_ready, mem_ready}, 64'd0);
        reset = 1'b1;
        idle_inputs();
    endtask

    // Random-phase reference state
    int          m_last;   // 0 = ALU granted last, 1 = MEM
    int          m_cnt;
    logic [4:0]  m_rd;
    logic [63:0] m_data;
    logic        a_pend, b_pend;
    logic [4:0]  a_rd, b_rd;
    logic [63:0] a_data, b_data;

    initial begin
        reset = 1'b1;
        idle_inputs();

        //              hold av ard  ad     mv mrd mdata  ear emr ewe erd edata  chk cnt
        vt[0]  = '{1'b0,1'b1,5'd20,64'd32, 1'b0,5'd0, 64'd0,  1'b1,1'b0,1'b1,5'd20,64'd32, 1'b1,1};
        vt[1]  = '{1'b0,1'b1,5'd10,64'd11, 1'b1,5'd20,64'd21, 1'b0,1'b1,1'b1,5'd20,64'd21, 1'b1,2};
        vt[2]  = '{1'b0,1'b1,5'd10,64'd12, 1'b1,5'd20,64'd22, 1'b1,1'b0,1'b1,5'd10,64'd12, 1'b1,3};
        vt[3]  = '{1'b0,1'b1,5'd10,64'd13, 1'b1,5'd20,64'd23, 1'b0,1'b1,1'b1,5'd20,64'd23, 1'b1,4};
        vt[4]  = '{1'b0,1'b0,5'd0, 64'd0,  1'b1,5'd0, 64'd99, 1'b0,1'b1,1'b0,5'd0, 64'd0,  1'b0,4};
        vt[5]  = '{1'b1,1'b1,5'd7, 64'd70, 1'b1,5'd8, 64'd80, 1'b0,1'b0,1'b0,5'd0, 64'd0,  1'b0,4};
        vt[6]  = '{1'b1,1'b1,5'd7, 64'd70, 1'b1,5'd8, 64'd80, 1'b0,1'b0,1'b0,5'd0, 64'd0,  1'b0,4};
        vt[7]  = '{1'b1,1'b1,5'd7, 64'd70, 1'b1,5'd8, 64'd80, 1'b0,1'b0,1'b0,5'd0, 64'd0,  1'b0,4};
        vt[8]  = '{1'b0,1'b1,5'd7, 64'd70, 1'b1,5'd8, 64'd80, 1'b1,1'b0,1'b1,5'd7, 64'd70, 1'b1,5};
        vt[9]  = '{1'b0,1'b0,5'd0, 64'd0,  1'b0,5'd0, 64'd0,  1'b0,1'b0,1'b0,5'd7, 64'd70, 1'b1,5};
        vt[10] = '{1'b0,1'b0,5'd0, 64'd0,  1'b1,5'd3, 64'hDEAD,1'b0,1'b1,1'b1,5'd3,64'hDEAD,1'b1,6};
        vt[11] = '{1'b0,1'b1,5'd4, 64'd5,  1'b0,5'd0, 64'd0,  1'b1,1'b0,1'b1,5'd4, 64'd5,  1'b1,7};
        vt[12] = '{1'b0,1'b1,5'd4, 64'd6,  1'b0,5'd0, 64'd0,  1'b1,1'b0,1'b1,5'd4, 64'd6,  1'b1,8};
        vt[13] = '{1'b0,1'b0,5'd0, 64'd0,  1'b1,5'd9, 64'd1,  1'b0,1'b1,1'b1,5'd9, 64'd1,  1'b1,9};

        do_reset();
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) begin
            hold = vt[i].hold;
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
            mem_valid = vt[i].mv; mem_rd = vt[i].mrd; mem_data = vt[i].md;
            #2;
            chk($sformatf("v%0d_alu_ready", i), 64'(alu_ready), 64'(vt[i].ear));
            chk($sformatf("v%0d_mem_ready", i), 64'(mem_ready), 64'(vt[i].emr));
            @(posedge clk); #1;
            chk($sformatf("v%0d_regwrite", i), 64'(RegWrite), 64'(vt[i].ewe));
            chk($sformatf("v%0d_count", i), 64'(wr_count), 64'(vt[i].ecnt % 16));
            if (vt[i].chk_rd) begin
                chk($sformatf("v%0d_rd", i), 64'(RD), 64'(vt[i].erd));
                chk($sformatf("v%0d_wdata", i), WriteData, vt[i].edata);
            end
        end
        idle_inputs();

        // Asynchronous reset while a write is staged clears it without a clock edge.
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 64'h1234;
        @(posedge clk); #1;
        chk("async_pre_regwrite", 64'(RegWrite), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_regwrite", 64'(RegWrite), 64'd0);
        chk("async_count", 64'(wr_count), 64'd0);
        chk("async_alu_ready", 64'(alu_ready), 64'd0);
        reset = 1'b1;
        idle_inputs();
        @(posedge clk); #1;

        // After reset ALU wins the first tie.
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 64'd100;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'd200;
        #2;
        chk("tie_after_reset_alu", 64'(alu_ready), 64'd1);
        chk("tie_after_reset_mem", 64'(mem_ready), 64'd0);
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;

        // Counter wrap: 16 back-to-back writes to rd=5 starting from zero.
        do_reset();
        @(posedge clk); #1;
        alu_valid = 1'b1; alu_rd = 5'd5;
        for (int i = 0; i < 16; i++) begin
            alu_data = 64'(i + 1000);
            @(posedge clk); #1;
            chk($sformatf("wrap_count_%0d", i), 64'(wr_count), 64'((i + 1) % 16));
            chk($sformatf("wrap_we_%0d", i), 64'(RegWrite), 64'd1);
        end
        idle_inputs();

        // Random traffic against the reference model.
        do_reset();
        m_last = 1; m_cnt = 0; m_rd = '0; m_data = '0;
        a_pend = 1'b0; b_pend = 1'b0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        @(posedge clk); #1;
        for (int c = 0; c < 400; c++) begin
            logic ga, gb, we_exp, h;
            if (!a_pend && ($urandom_range(0, 3) != 0)) begin
                a_pend = 1'b1; a_rd = 5'($urandom_range(0, 31));
                a_data = {$urandom, $urandom};
            end
            if (!b_pend && ($urandom_range(0, 2) != 0)) begin
                b_pend = 1'b1; b_rd = 5'($urandom_range(0, 31));
                b_data = {$urandom, $urandom};
            end
            h = ($urandom_range(0, 4) == 0);
            hold = h;
            alu_valid = a_pend; alu_rd = a_rd; alu_data = a_data;
            mem_valid = b_pend; mem_rd = b_rd; mem_data = b_data;

            ga = 1'b0; gb = 1'b0;
            if (!h) begin
                if (a_pend && b_pend) begin
                    if (m_last == 1) ga = 1'b1; else gb = 1'b1;
                end else begin
                    ga = a_pend;
                    gb = b_pend;
                end
            end
            #2;
            chk("rnd_alu_ready", 64'(alu_ready), 64'(ga));
            chk("rnd_mem_ready", 64'(mem_ready), 64'(gb));

            we_exp = 1'b0;
            if (ga) begin
                m_last = 0; a_pend = 1'b0;
                if (a_rd != 0) begin we_exp = 1'b1; m_rd = a_rd; m_data = a_data; end
            end else if (gb) begin
                m_last = 1; b_pend = 1'b0;
                if (b_rd != 0) begin we_exp = 1'b1; m_rd = b_rd; m_data = b_data; end
            end
            if (we_exp) m_cnt = (m_cnt + 1) % 16;

            @(posedge clk); #1;
            chk("rnd_regwrite", 64'(RegWrite), 64'(we_exp));
            chk("rnd_count", 64'(wr_count), 64'(m_cnt));
            if (we_exp) begin
                chk("rnd_rd", 64'(RD), 64'(m_rd));
                chk("rnd_wdata", WriteData, m_data);
            end
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
